// File: rtl/ifu_if.sv
`default_nettype none
// ============================================================================
// ifu_if : instruction-memory fetch handshake (req/addr out, ack/rdata back)
// Rev 1.0
// ============================================================================
interface ifu_if;
    logic        req;
    logic [31:0] addr;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, output addr, input ack, input rdata);
    modport slave  (input req, input addr, output ack, output rdata);
endinterface
`default_nettype wire

// File: rtl/ifu.sv
`default_nettype none
// ============================================================================
// ifu : PC, instruction register, imem fetch and next-PC selection
// Rev 1.0
// ============================================================================
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    ifu_if.master            imem,
    output logic             ir_valid,
    output logic [31:0]      ir,
    output logic [31:0]      pc,
    output logic [31:0]      pc_plus4,
    output logic [15:0]      imm16,
    input  wire logic [31:0] ext_imm,
    input  wire logic [1:0]  npc_sel,
    input  wire logic        br_taken,
    input  wire logic [31:0] jr_target,
    input  wire logic        advance,
    input  wire logic        stall,
    output logic             fault,
    output logic [31:0]      fault_addr
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_VALID = 2'd2;
    localparam logic [1:0] S_FAULT = 2'd3;

    localparam logic [1:0] NPC_SEQ = 2'b00;
    localparam logic [1:0] NPC_BR  = 2'b01;
    localparam logic [1:0] NPC_J   = 2'b10;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_ir;
    logic [31:0] r_pc;
    logic        r_fault;
    logic [31:0] r_fault_addr;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_npc;
    logic        w_accept;
    logic        w_misaligned;
    logic        w_capture;

    assign w_pc_plus4   = r_pc + 32'd4;
    assign w_accept     = advance & ~stall;
    assign w_misaligned = (w_npc[1:0] != 2'b00);
    assign w_capture    = (r_state == S_FETCH) & imem.ack;

    // All sources wrap modulo 2^32; the alignment check is applied to every source.
    always_comb begin
        w_npc = w_pc_plus4;
        case (npc_sel)
            NPC_SEQ: w_npc = w_pc_plus4;
            NPC_BR:  w_npc = br_taken ? (w_pc_plus4 + (ext_imm << 2)) : w_pc_plus4;
            NPC_J:   w_npc = {w_pc_plus4[31:28], r_ir[25:0], 2'b00};
            default: w_npc = jr_target;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  w_state_nxt = S_FETCH;
            S_FETCH: if (imem.ack) w_state_nxt = S_VALID;
            S_VALID: if (w_accept) w_state_nxt = w_misaligned ? S_FAULT : S_FETCH;
            default: w_state_nxt = S_FAULT;
        endcase
    end

    always_comb begin
        imem.req = (r_state == S_FETCH);
        ir_valid = (r_state == S_VALID);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc   <= RESET_PC;
            r_ir         <= 32'd0;
            r_pc         <= RESET_PC;
            r_fault      <= 1'b0;
            r_fault_addr <= 32'd0;
        end else begin
            if (w_capture) begin
                r_ir <= imem.rdata;
                r_pc <= r_fetch_pc;
            end
            if ((r_state == S_VALID) && w_accept) begin
                if (w_misaligned) begin
                    r_fault      <= 1'b1;
                    r_fault_addr <= w_npc;
                end else begin
                    r_fetch_pc   <= w_npc;
                end
            end
        end
    end

    assign imem.addr  = r_fetch_pc;
    assign ir         = r_ir;
    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign imm16      = r_ir[15:0];
    assign fault      = r_fault;
    assign fault_addr = r_fault_addr;

endmodule
`default_nettype wire

// File: tb/tb_ifu.sv
`default_nettype none
// ============================================================================
// tb_ifu : randomized fetch/advance traffic checked against a transaction model
// Rev 1.0
// ============================================================================
module tb_ifu;

    localparam logic [31:0] C_RESET_PC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        ir_valid;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [15:0] imm16;
    logic [31:0] ext_imm;
    logic [1:0]  npc_sel;
    logic        br_taken;
    logic [31:0] jr_target;
    logic        advance;
    logic        stall;
    logic        fault;
    logic [31:0] fault_addr;

    ifu_if u_if ();

    ifu #(.RESET_PC(C_RESET_PC)) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem       (u_if),
        .ir_valid   (ir_valid),
        .ir         (ir),
        .pc         (pc),
        .pc_plus4   (pc_plus4),
        .imm16      (imm16),
        .ext_imm    (ext_imm),
        .npc_sel    (npc_sel),
        .br_taken   (br_taken),
        .jr_target  (jr_target),
        .advance    (advance),
        .stall      (stall),
        .fault      (fault),
        .fault_addr (fault_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction memory contents, addressed by byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_3000) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    // Reference model: what the fetch unit is doing, in transaction terms.
    typedef enum int {M_IDLE, M_FETCHING, M_HOLDING, M_FAULTED} mode_t;
    mode_t       m_mode;
    logic [31:0] m_fetch;
    logic [31:0] m_pc;
    logic [31:0] m_ir;
    logic        m_fault;
    logic [31:0] m_faddr;
    int          fault_cycles;

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_fetch = C_RESET_PC;
        m_pc    = C_RESET_PC;
        m_ir    = 32'd0;
        m_fault = 1'b0;
        m_faddr = 32'd0;
    endtask

    task automatic check_all();
        chk("imem_req", {31'd0, u_if.req}, {31'd0, m_mode == M_FETCHING});
        chk("imem_addr", u_if.addr, m_fetch);
        chk("ir_valid", {31'd0, ir_valid}, {31'd0, m_mode == M_HOLDING});
        chk("ir", ir, m_ir);
        chk("pc", pc, m_pc);
        chk("pc_plus4", pc_plus4, m_pc + 32'd4);
        chk("imm16", {16'd0, imm16}, {16'd0, m_ir[15:0]});
        chk("fault", {31'd0, fault}, {31'd0, m_fault});
        chk("fault_addr", fault_addr, m_faddr);
    endtask

    // Asynchronous reset while the DUT may be mid-fetch; a late ack must be ignored.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        u_if.ack   = 1'b1;
        u_if.rdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        u_if.ack = 1'b0;
        rst_n    = 1'b1;
        fault_cycles = 0;
    endtask

    logic [31:0] target;
    logic [31:0] p4;
    logic [31:0] npc;
    int          r;

    initial begin
        rst_n      = 1'b0;
        u_if.ack   = 1'b0;
        u_if.rdata = 32'd0;
        ext_imm    = 32'd0;
        npc_sel    = 2'b00;
        br_taken   = 1'b0;
        jr_target  = 32'd0;
        advance    = 1'b0;
        stall      = 1'b0;
        fault_cycles = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst_n = 1'b1;

        for (int cyc = 0; cyc < 4000; cyc++) begin
            if ((m_mode == M_FETCHING && $urandom_range(0, 40) == 0) ||
                (m_mode == M_FAULTED && fault_cycles >= 3)) begin
                reset_pulse();
            end

            // Memory side: ack is random and may land in the same cycle as req.
            u_if.ack   = ($urandom_range(0, 2) != 0);
            u_if.rdata = mem_word(u_if.addr);

            // Decode side: extender output follows the spec's sign extension of imm16.
            ext_imm   = {{16{m_ir[15]}}, m_ir[15:0]};
            advance   = ($urandom_range(0, 9) < 7);
            stall     = ($urandom_range(0, 3) == 0);
            npc_sel   = 2'($urandom_range(0, 3));
            br_taken  = $urandom_range(0, 1) == 1;
            r = $urandom_range(0, 19);
            if (r == 0)      target = $urandom | 32'd1;
            else if (r < 3)  target = 32'hFFFF_FFFC;
            else if (r < 6)  target = C_RESET_PC;
            else             target = {$urandom_range(0, 32'hFFFF) , 16'd0} | {16'd0, 14'($urandom), 2'b00};
            jr_target = target;

            case (m_mode)
                M_IDLE: m_mode = M_FETCHING;
                M_FETCHING: begin
                    if (u_if.ack) begin
                        m_ir   = mem_word(m_fetch);
                        m_pc   = m_fetch;
                        m_mode = M_HOLDING;
                    end
                end
                M_HOLDING: begin
                    if (advance && !stall) begin
                        p4 = m_pc + 32'd4;
                        case (npc_sel)
                            2'b00:   npc = p4;
                            2'b01:   npc = br_taken ? p4 + ext_imm * 32'd4 : p4;
                            2'b10:   npc = {p4[31:28], m_ir[25:0], 2'b00};
                            default: npc = jr_target;
                        endcase
                        if (npc % 4 != 0) begin
                            m_fault = 1'b1;
                            m_faddr = npc;
                            m_mode  = M_FAULTED;
                        end else begin
                            m_fetch = npc;
                            m_mode  = M_FETCHING;
                        end
                    end
                end
                default: fault_cycles++;
            endcase

            @(posedge clk);
            #1;
            check_all();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ifu.md
# ifu

Instruction fetch unit for the multi-cycle MIPS core. It owns the program counter, fetches words from instruction memory over a req/ack handshake, and holds the fetched word in the instruction register. It drives `imm16` into the immediate extender and consumes the extender's 32-bit result to form branch targets. It also computes the next PC for sequential, branch, jump and jump-register flow.

## Interface
- `RESET_PC`, 32'h0000_3000, first fetch address after reset; must be word-aligned.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request to instruction memory.
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1.
- `imem_ack`  in  1  memory returns data this cycle; may arrive in the same cycle as `imem_req`.
- `imem_rdata`  in  32  instruction word; sampled only when `imem_req`&`imem_ack`.
- `ir_valid`  out  1  `ir`/`pc` hold a valid instruction.
- `ir`  out  32  instruction register.
- `pc`  out  32  address of the instruction in `ir`.
- `pc_plus4`  out  32  `pc`+4 (combinational from `pc`).
- `imm16`  out  16  `ir[15:0]`, to extender input.
- `ext_imm`  in  32  extender output (sign-extended `imm16` for branches).
- `npc_sel`  in  2  00 seq, 01 branch, 10 jump (j/jal), 11 jr.
- `br_taken`  in  1  branch condition result; used only when `npc_sel`=01.
- `jr_target`  in  32  rs value for jr.
- `advance`  in  1  decode/execute has finished with `ir`; next-PC inputs are valid this cycle.
- `stall`  in  1  hold; overrides `advance`.
- `fault`  out  1  sticky misaligned-target fault.
- `fault_addr`  out  32  offending target address.

## Operation
- Four states: IDLE, FETCH, VALID, FAULT.
- IDLE: entered on reset. Outputs `imem_req`=0. Goes to FETCH on the first clock edge after `rst_n` deasserts.
- FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`. On `imem_ack`=1: `ir`<=`imem_rdata`, `pc`<=`fetch_pc`, go to VALID. Otherwise stay in FETCH with the address unchanged. `stall` has no effect in FETCH.
- VALID: `ir_valid`=1, `imem_req`=0.
  - If `advance`=1 and `stall`=0, compute npc:
    - 00: `pc`+4.
    - 01: `br_taken` ? `pc`+4+(`ext_imm`<<2) : `pc`+4.
    - 10: {`pc_plus4[31:28]`, `ir[25:0]`, 2'b00}.
    - 11: `jr_target`.
  - If npc[1:0]≠0: `fault`<=1, `fault_addr`<=npc, go to FAULT.
  - Otherwise `fetch_pc`<=npc and go to FETCH.
  - If `advance`=0 or `stall`=1, hold everything.
- FAULT: terminal until reset. `imem_req`=0, `ir_valid`=0, `fault`=1. `ir`/`pc` retain their last values.
- All PC arithmetic is modulo 2^32: 32'hFFFF_FFFC+4 wraps to 0, and branch offsets wrap likewise. No fault is raised on wrap.
- Only npc sourced from `jr_target` can be misaligned, because the other sources are aligned by construction. The check is still applied uniformly.

## Timing
- Reset values:
  - `imem_req`=0, `imem_addr`=RESET_PC, `fetch_pc`=RESET_PC.
  - `ir`=0, `pc`=RESET_PC, `ir_valid`=0.
  - `fault`=0, `fault_addr`=0.
  - state=IDLE.
- Reset is asynchronous: asserting `rst_n`=0 in any state, including mid-FETCH with a request outstanding, returns all registers to reset values immediately. A late `imem_ack` is ignored.
- With a zero-wait memory (ack in the same cycle as req), throughput is one instruction per 2 cycles: FETCH, then VALID.
- Each memory wait cycle adds one cycle in FETCH.
- `ir_valid` rises on the edge that captures `imem_ack` and falls on the edge that accepts `advance`.
- `imm16`, `pc_plus4` and `imem_addr` are combinational from registers. No path exists from `imem_rdata` to any output within the same cycle.
- `advance` and `stall` asserted together act as a stall.

## Test plan
- Reset release, zero-wait memory returning 32'h2008_0005 at 0x3000, `advance`=1 with `npc_sel`=00 → `imem_req` high at cycle 1; `ir`=32'h2008_0005, `pc`=0x3000, `ir_valid`=1 at cycle 2; next fetch at 0x3004.
- `ir`=beq with `imm16`=16'hFFFF, `ext_imm`=32'hFFFF_FFFF, `br_taken`=1, `pc`=0x3010 → next `imem_addr`=0x3010; with `br_taken`=0 → 0x3014.
- j with `ir[25:0]`=26'h0000C04, `pc`=0x3000 → `imem_addr`=0x0000_3010. jr with `jr_target`=0x3002 → `fault`=1, `fault_addr`=0x3002, `imem_req` stays 0.
- Memory with 3 wait cycles → `imem_addr` stable for 4 cycles, `ir` captured on the ack edge. Hold `stall`=1 with `advance`=1 for 5 cycles in VALID → no new request until `stall` drops.
- `pc`=32'hFFFF_FFFC, `npc_sel`=00 → next fetch at 0x0000_0000 with no fault.
- Assert `rst_n`=0 mid-FETCH, then deliver `imem_ack` → outputs at reset values, `ir` remains 0, refetch from 0x3000 after release.
